// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-source, control/status and instruction-memory write
// signals of the instruction loader. The master side (byte source / CPU
// control) drives start, length and the byte stream; the slave side is the
// loader itself.
`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif
`ifndef INSTRSIZE
`define INSTRSIZE 32
`endif

interface instr_loader_if #(
   parameter int INSTRNUM = 1024
);
   localparam int LEN_W = $clog2(INSTRNUM) + 1;

   logic                     start;
   logic [LEN_W-1:0]         length;
   logic                     byte_valid;
   logic [7:0]               byte_data;
   logic                     byte_ready;
   logic                     mem_we;
   logic [`REGDATASIZE-1:0]  mem_addr;
   logic [`INSTRSIZE-1:0]    mem_wdata;
   logic                     busy;
   logic                     done;
   logic                     error;

   modport master (
      output start, length, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );

   modport slave (
      input  start, length, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: assembles a byte stream into little-endian 32-bit
// instruction words and writes word k to instruction memory at byte
// address k*4. busy holds the CPU off while a load is in progress; done
// pulses once at the end; error flags an illegal length.
// Optional feature: define LOADER_CHECKSUM_EN to require a 4-byte
// little-endian trailer equal to the XOR of all written words; a mismatch
// sets error.
`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif
`ifndef INSTRSIZE
`define INSTRSIZE 32
`endif

module instr_loader #(
   parameter int INSTRNUM = 1024
) (
   input  logic          clk,
   input  logic          reset,
   instr_loader_if.slave bus
);
   localparam int LEN_W  = $clog2(INSTRNUM) + 1;
   localparam int ADDR_W = `REGDATASIZE;
   localparam int DATA_W = `INSTRSIZE;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] CHECK = 3'd3;
`endif
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;          // length latched at accepted start
   logic [LEN_W-1:0]  word_idx_q, word_idx_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       word_q, word_d;        // first three bytes of the word
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   logic              byte_ready;
   logic              xfer;
   logic              len_ok;
   logic [DATA_W-1:0] assembled;
   logic [LEN_W-1:0]  word_idx_inc;

   // Byte acceptance window: only while collecting instruction or trailer bytes.
   always_comb begin
      byte_ready = (state_q == LOAD);
`ifdef LOADER_CHECKSUM_EN
      if (state_q == CHECK) byte_ready = 1'b1;
`endif
   end

   assign xfer         = bus.byte_valid && byte_ready;
   assign len_ok       = (bus.length != '0) && (bus.length <= LEN_W'(INSTRNUM));
   assign assembled    = {bus.byte_data, word_q};
   assign word_idx_inc = word_idx_q + LEN_W'(1);

   // Next-state and datapath logic for the load sequence.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d     = state_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  state_d    = LOAD;
                  len_d      = bus.length;
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  error_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  csum_d     = '0;
`endif
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               if (byte_cnt_q == 2'd3) begin
                  // Word complete: present it to memory for the single WRITE cycle.
                  mem_wdata_d = assembled;
                  mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                  byte_cnt_d  = '0;
                  state_d     = WRITE;
               end else begin
                  word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         WRITE: begin
            word_idx_d = word_idx_inc;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ mem_wdata_q;
            state_d    = (word_idx_inc < len_q) ? LOAD : CHECK;
`else
            state_d    = (word_idx_inc < len_q) ? LOAD : DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) begin
               if (byte_cnt_q == 2'd3) begin
                  if (assembled != csum_q) error_d = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = DONE;
               end else begin
                  word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset overriding start and byte transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         word_idx_q  <= '0;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q     <= state_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         word_q      <= word_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.mem_we     = (state_q == WRITE);
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.error      = error_q;
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter INSTRNUM, default 1024, is the instruction memory depth in 32-bit words.
REQ-002 Port clk  input  1  is the single clock, and all logic is rising-edge triggered.
REQ-003 Port reset  input  1  is a synchronous, active-high reset.
REQ-004 Port start  input  1  is a load request, sampled only in IDLE.
REQ-005 Port length  input  $clog2(INSTRNUM)+1  gives the number of words to load.
REQ-006 Port byte_valid  input  1  marks the source byte as valid.
REQ-007 Port byte_data  input  8  carries the source byte.
REQ-008 Port byte_ready  output  1  indicates the loader accepts a byte this cycle.
REQ-009 Port mem_we  output  1  is the instruction-memory write strobe.
REQ-010 Port mem_addr  output  `REGDATASIZE  is the byte address, always word index*4.
REQ-011 Port mem_wdata  output  `INSTRSIZE  is the assembled instruction word.
REQ-012 Port busy  output  1  is high in every state except IDLE, so the CPU can be held.
REQ-013 Port done  output  1  is a one-cycle pulse marking load completion.
REQ-014 Port error  output  1  is a sticky flag, cleared by reset or by an accepted start.

Function
REQ-015 The FSM SHALL use the states IDLE, LOAD, WRITE, CHECK (macro only) and DONE.
REQ-016 In IDLE, with start=1 and 1<=length<=INSTRNUM, the next state SHALL be LOAD, word index 0, byte count 0, and error cleared.
REQ-017 In IDLE, with start=1 and length=0 or length>INSTRNUM, the block SHALL stay in IDLE and set error on the next cycle.
REQ-018 byte_ready SHALL be 1 only in LOAD and CHECK; a byte transfers when byte_valid&byte_ready.
REQ-019 Bytes SHALL assemble little-endian: the 1st byte lands in [7:0] and the 4th in [31:24].
REQ-020 Accepting the 4th byte SHALL move the FSM to WRITE; WRITE lasts exactly one cycle with mem_we=1, byte_ready=0.
REQ-021 In WRITE, mem_addr SHALL equal word_index*4, zero-extended, and mem_wdata SHALL equal the assembled word.
REQ-022 After WRITE, word_index SHALL increment; the next state is LOAD if word_index+1<length, else CHECK (macro) or DONE.
REQ-023 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 byte_valid gaps SHALL stall assembly without losing the partial word.
REQ-026 Back-to-back valid bytes SHALL give exactly 5 cycles per word: 4 LOAD plus 1 WRITE.
REQ-027 mem_we SHALL never assert outside WRITE; mem_addr and mem_wdata SHALL hold their last values otherwise.

Reset
REQ-028 reset=1 at any rising edge SHALL force IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, and word index and byte count at 0.
REQ-029 Reset mid-load SHALL discard the partial word, and no write SHALL occur in the reset cycle.
REQ-030 Reset SHALL take priority over start and over byte transfers in the same cycle.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN SHALL enable an XOR checksum of all written words, with the running value cleared on accepted start.
REQ-032 With the macro defined, after the last WRITE the FSM SHALL enter CHECK, accept 4 more little-endian bytes, set error on mismatch, then go to DONE (done pulses regardless).
REQ-033 Without the macro, the CHECK state and checksum logic SHALL be absent, and error SHALL reflect only an illegal length.

Verification
REQ-034 start with length=2, bytes 0x20,0x00,0x80,0xD2,0x41,0x00,0x00,0x8B back-to-back -> writes 0xD2800020@0x0, then 0x8B000041@0x4; done pulses at cycle 11 after start; busy=0 afterwards.
REQ-035 length=0, and separately length=INSTRNUM+1 -> no mem_we, error=1, busy=0; a following legal start clears error.
REQ-036 length=1 with byte_valid toggling 1,0,0,1,1,0,1 -> a single write of the correct word, with no write before the 4th accepted byte.
REQ-037 Reset asserted after 2 bytes of word 3 -> no further mem_we, all outputs at reset values; a new start with length=1 writes at address 0x0.
REQ-038 Macro on, length=2 with words 0x11111111, 0x22222222 and trailer 0x33333333 -> error=0; the same load with trailer 0x33333334 -> error=1, and done still pulses.
REQ-039 start pulsed during LOAD with length=5 -> ignored; the original length completes, with exactly that many writes.
